// File: rtl/orv64_param_pkg.sv
// Shared types for the orv64 regfile debug access path.
package orv64_param_pkg;

    localparam int unsigned RF_WIDTH  = 64;
    localparam int unsigned RF_DEPTH  = 32;
    localparam int unsigned RF_ADDR_W = $clog2(RF_DEPTH);

    typedef enum logic [1:0] {
        RF_DBG_IDLE   = 2'd0,
        RF_DBG_ARB    = 2'd1,
        RF_DBG_RD_CAP = 2'd2,
        RF_DBG_RESP   = 2'd3
    } rf_dbg_state_e;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_WIDTH-1:0]  wdata;
    } rf_dbg_req_t;

    typedef struct packed {
        logic [RF_WIDTH-1:0] rdata;
        logic                err;
    } rf_dbg_resp_t;

endpackage

// File: rtl/orv64_rf_dbg_access.sv
// Debug-side GPR access: borrows one regfile read and one write port from the
// pipeline via rf_req/rf_gnt and returns results on a valid/ready channel.
module orv64_rf_dbg_access
    import orv64_param_pkg::*;
#(
    parameter int unsigned WIDTH       = RF_WIDTH,
    parameter int unsigned DEPTH       = RF_DEPTH,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [WIDTH-1:0]  dbg_req_wdata,
    output logic              dbg_resp_valid,
    input  logic              dbg_resp_ready,
    output logic [WIDTH-1:0]  dbg_resp_rdata,
    output logic              dbg_resp_err,
    output logic              rf_req,
    input  logic              rf_gnt,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [WIDTH-1:0]  rf_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [WIDTH-1:0]  rf_wd
);

    localparam int unsigned       CNT_W    = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

    rf_dbg_state_e     state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;

    // Next-state, datapath and port decode
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        dbg_req_ready  = 1'b0;
        dbg_resp_valid = 1'b0;
        dbg_resp_rdata = '0;
        dbg_resp_err   = 1'b0;
        rf_req         = 1'b0;
        rf_re          = 1'b0;
        rf_ra          = '0;
        rf_we          = 1'b0;
        rf_wa          = '0;
        rf_wd          = '0;

        case (state_q)
            RF_DBG_IDLE: begin
                dbg_req_ready = 1'b1;
                if (dbg_req_valid) begin
                    we_d    = dbg_req_we;
                    addr_d  = dbg_req_addr;
                    wdata_d = dbg_req_wdata;
                    if (!halted) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RF_DBG_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = RF_DBG_ARB;
                    end
                end
            end

            RF_DBG_ARB: begin
                rf_req = 1'b1;
                // A grant in the expiry cycle still wins over the timeout
                if (rf_gnt) begin
                    if (we_q) begin
                        if (addr_q != '0) begin
                            rf_we = 1'b1;
                            rf_wa = addr_q;
                            rf_wd = wdata_q;
                        end
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = RF_DBG_RESP;
                    end else begin
                        rf_re   = 1'b1;
                        rf_ra   = addr_q;
                        state_d = RF_DBG_RD_CAP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RF_DBG_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RF_DBG_RD_CAP: begin
                // Keep the read port reserved while its data returns
                rf_req  = 1'b1;
                rdata_d = (addr_q == '0) ? '0 : rf_rd;
                err_d   = 1'b0;
                state_d = RF_DBG_RESP;
            end

            RF_DBG_RESP: begin
                dbg_resp_valid = 1'b1;
                dbg_resp_rdata = rdata_q;
                dbg_resp_err   = err_q;
                if (dbg_resp_ready) begin
                    state_d = RF_DBG_IDLE;
                end
            end

            default: begin
                state_d = RF_DBG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_DBG_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
